flash_playback_ctrl: RTL and testbench

Sequences 32-bit reads from the board flash controller for audio playback and delivers one 16-bit sample per sample tick. Sits between the synchronized sample-rate tick and the flash Avalon-MM read port, owning the playback address, direction, restart and wrap-around. It drives the flash read handshake itself. Each fetched word supplies two samples, so flash is accessed on every second tick.

---
 rtl/flash_playback_ctrl.sv | 164 ++++++++++++++++
 tb/tb_flash_playback_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_playback_ctrl.sv
// Audio playback sequencer: fetches 32-bit words from the board flash over
// Avalon-MM and hands out one 16-bit sample per sample tick. Each fetched word
// carries two samples, so flash is only read on every second serviced tick.
//
//   state | meaning
//   IDLE  | waiting for a sample tick; restart applies immediately here
//   REQ   | flash_read asserted, address held until waitrequest drops
//   WAIT  | read accepted, waiting for readdatavalid
//   EMIT  | sample_valid high; advance half/address or apply pending restart
module flash_playback_ctrl #(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              dir,
  input  logic              restart,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  output logic [3:0]        flash_byteenable,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       sample,
  output logic              sample_valid,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word_q;
  logic              have_word_q;
  logic              half_q;
  logic              word_dir_q;
  logic              restart_pend_q;
  logic [15:0]       sample_q;
  logic              sample_valid_q;
  logic              flash_read_q;
  logic              overrun_q;

  logic              tick_play;
  logic [ADDR_W-1:0] addr_step_d;
  logic [ADDR_W-1:0] addr_restart_d;

  // Upper half is taken when the word plays backward XOR the second half is due.
  function automatic logic [15:0] pick_half(input logic [31:0] w, input logic use_hi);
    return use_hi ? w[31:16] : w[15:0];
  endfunction

  assign tick_play = sample_tick & play;

  // Next word address after a fully consumed word, wrapping at the region ends.
  always_comb begin
    addr_step_d    = addr_q;
    addr_restart_d = dir ? END_ADDR : START_ADDR;
    if (word_dir_q) begin
      addr_step_d = (addr_q == START_ADDR) ? END_ADDR : (addr_q - ADDR_ONE);
    end else begin
      addr_step_d = (addr_q == END_ADDR) ? START_ADDR : (addr_q + ADDR_ONE);
    end
  end

  // Playback FSM with all outputs registered.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      addr_q         <= START_ADDR;
      word_q         <= 32'h0;
      have_word_q    <= 1'b0;
      half_q         <= 1'b0;
      word_dir_q     <= 1'b0;
      restart_pend_q <= 1'b0;
      sample_q       <= 16'h0000;
      sample_valid_q <= 1'b0;
      flash_read_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (restart) begin
            // A coincident tick is dropped: the restart address is not yet
            // visible on flash_address, so fetching now would read stale data.
            addr_q         <= addr_restart_d;
            have_word_q    <= 1'b0;
            half_q         <= 1'b0;
            overrun_q      <= 1'b0;
            restart_pend_q <= 1'b0;
          end else if (tick_play) begin
            if (have_word_q) begin
              sample_q       <= pick_half(word_q, word_dir_q ^ half_q);
              sample_valid_q <= 1'b1;
              state_q        <= S_EMIT;
            end else begin
              flash_read_q <= 1'b1;
              state_q      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (restart) restart_pend_q <= 1'b1;
          if (!flash_waitrequest) begin
            flash_read_q <= 1'b0;
            word_dir_q   <= dir;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (restart) restart_pend_q <= 1'b1;
          if (flash_readdatavalid) begin
            word_q         <= flash_readdata;
            have_word_q    <= 1'b1;
            half_q         <= 1'b0;
            sample_q       <= pick_half(flash_readdata, word_dir_q);
            sample_valid_q <= 1'b1;
            state_q        <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (restart || restart_pend_q) begin
            addr_q         <= addr_restart_d;
            have_word_q    <= 1'b0;
            half_q         <= 1'b0;
            overrun_q      <= 1'b0;
            restart_pend_q <= 1'b0;
          end else if (!half_q) begin
            half_q <= 1'b1;
          end else begin
            have_word_q <= 1'b0;
            half_q      <= 1'b0;
            addr_q      <= addr_step_d;
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          flash_read_q <= 1'b0;
        end
      endcase
      // Placed after the case so a dropped tick wins over a same-cycle clear.
      if (tick_play && (state_q != S_IDLE)) overrun_q <= 1'b1;
    end
  end

  assign flash_read       = flash_read_q;
  assign flash_address    = addr_q;
  assign flash_byteenable = 4'hF;
  assign sample           = sample_q;
  assign sample_valid     = sample_valid_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_flash_playback_ctrl.sv
// Directed bench for flash_playback_ctrl with a small Avalon flash model.
`timescale 1ns/1ps
module tb_flash_playback_ctrl;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        play;
  logic        dir;
  logic        restart;
  logic        flash_read;
  logic [22:0] flash_address;
  logic [3:0]  flash_byteenable;
  logic        flash_waitrequest;
  logic [31:0] flash_readdata;
  logic        flash_readdatavalid;
  logic [15:0] sample;
  logic        sample_valid;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int ws_cfg  = 0;
  int lat_cfg = 1;
  int ws_left = 0;
  int pend_cnt = 0;
  logic [31:0] pend_data;
  int reads = 0;
  int read_hi = 0;
  int addr_unstable = 0;
  logic in_burst = 1'b0;
  logic [22:0] hold_addr;

  int sv_count = 0;
  logic [15:0] last_sample = 16'h0;

  flash_playback_ctrl dut (
    .clk_50              (clk_50),
    .reset               (reset),
    .sample_tick         (sample_tick),
    .play                (play),
    .dir                 (dir),
    .restart             (restart),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_byteenable    (flash_byteenable),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .sample              (sample),
    .sample_valid        (sample_valid),
    .overrun             (overrun)
  );

  always #5 clk_50 = ~clk_50;

  function automatic logic [31:0] word_at(input logic [22:0] a);
    if (a == 23'h0) return 32'hBBBB_AAAA;
    if (a == 23'h7FFFF) return 32'h1111_2222;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Flash model: ws_cfg waitstates per read, data lat_cfg cycles after acceptance.
  initial begin
    flash_waitrequest   = 1'b0;
    flash_readdatavalid = 1'b0;
    flash_readdata      = 32'h0;
    forever begin
      @(negedge clk_50);
      flash_readdatavalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          flash_readdatavalid = 1'b1;
          flash_readdata      = pend_data;
        end
      end
      if (flash_read) begin
        read_hi++;
        if (!in_burst) begin
          in_burst  = 1'b1;
          hold_addr = flash_address;
        end else if (flash_address !== hold_addr) begin
          addr_unstable++;
        end
        if (ws_left > 0) begin
          flash_waitrequest = 1'b1;
          ws_left--;
        end else begin
          flash_waitrequest = 1'b0;
          reads++;
          pend_data = word_at(flash_address);
          pend_cnt  = lat_cfg;
        end
      end else begin
        flash_waitrequest = 1'b0;
        ws_left  = ws_cfg;
        in_burst = 1'b0;
      end
    end
  end

  // Sample monitor.
  initial begin
    forever begin
      @(posedge clk_50);
      #1;
      if (sample_valid) begin
        sv_count++;
        last_sample = sample;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    @(negedge clk_50);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk_50);
    restart = 1'b0;
  endtask

  task automatic wait_sample(input string tag, input int prev);
    int k = 0;
    while (sv_count == prev && k < 40) begin
      @(negedge clk_50);
      k++;
    end
    if (sv_count == prev) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic tick_fetch(input string tag, input logic [22:0] exp_addr, input logic [15:0] exp);
    int prev = sv_count;
    pulse_tick();
    chk({tag, "_rd"}, {31'd0, flash_read}, 32'd1);
    chk({tag, "_addr"}, {9'd0, flash_address}, {9'd0, exp_addr});
    wait_sample(tag, prev);
    chk(tag, {16'd0, last_sample}, {16'd0, exp});
    cyc(12);
  endtask

  task automatic tick_held(input string tag, input logic [15:0] exp);
    pulse_tick();
    chk({tag, "_sv"}, {31'd0, sample_valid}, 32'd1);
    chk({tag, "_rd"}, {31'd0, flash_read}, 32'd0);
    chk(tag, {16'd0, sample}, {16'd0, exp});
    cyc(12);
  endtask

  initial begin
    int prev;
    int rprev;
    logic [31:0] w;
    reset = 1'b1; sample_tick = 1'b0; play = 1'b1; dir = 1'b0; restart = 1'b0;
    cyc(3);
    chk("rst_read", {31'd0, flash_read}, 32'd0);
    chk("rst_addr", {9'd0, flash_address}, 32'd0);
    chk("rst_be", {28'd0, flash_byteenable}, 32'hF);
    chk("rst_sample", {16'd0, sample}, 32'd0);
    chk("rst_sv", {31'd0, sample_valid}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    cyc(3);

    // Forward, zero waitstates, 1-cycle latency: exact latency checks.
    pulse_tick();
    chk("fw_read_n1", {31'd0, flash_read}, 32'd1);
    chk("fw_addr0", {9'd0, flash_address}, 32'd0);
    @(negedge clk_50);
    chk("fw_wait_rd", {31'd0, flash_read}, 32'd0);
    chk("fw_sv_early", {31'd0, sample_valid}, 32'd0);
    @(negedge clk_50);
    chk("fw_sv_k1", {31'd0, sample_valid}, 32'd1);
    chk("fw_s0", {16'd0, sample}, 32'hAAAA);
    @(negedge clk_50);
    chk("fw_sv_pulse", {31'd0, sample_valid}, 32'd0);
    cyc(16);
    tick_held("fw_s1", 16'hBBBB);
    tick_fetch("fw_w1", 23'h1, 16'h0001);
    tick_held("fw_w1h", 16'h5A5B);
    chk("fw_reads", reads, 32'd2);

    // Backward from END_ADDR, then backward wrap at START_ADDR.
    dir = 1'b1;
    pulse_restart();
    chk("bw_rst_addr", {9'd0, flash_address}, 32'h7FFFF);
    tick_fetch("bw_w0", 23'h7FFFF, 16'h1111);
    tick_held("bw_w0h", 16'h2222);
    tick_fetch("bw_w1", 23'h7FFFE, 16'hA5A4);
    tick_held("bw_w1h", 16'hFFFE);
    dir = 1'b0;
    pulse_restart();
    chk("fw_rst_addr", {9'd0, flash_address}, 32'h0);
    dir = 1'b1;
    tick_fetch("bw_s", 23'h0, 16'hBBBB);
    tick_held("bw_sh", 16'hAAAA);
    tick_fetch("bw_wrap", 23'h7FFFF, 16'h1111);
    tick_held("bw_wraph", 16'h2222);

    // Forward wrap at END_ADDR with a dir change in mid-word.
    pulse_restart();
    chk("bw_rst_addr2", {9'd0, flash_address}, 32'h7FFFF);
    dir = 1'b0;
    tick_fetch("dchg", 23'h7FFFF, 16'h2222);
    dir = 1'b1;
    tick_held("dchg_h", 16'h1111);
    tick_fetch("fw_wrap", 23'h0, 16'hBBBB);
    tick_held("fw_wraph", 16'hAAAA);

    // Five waitstates: request and address held, one read only.
    dir = 1'b0;
    pulse_restart();
    chk("ws_rst_addr", {9'd0, flash_address}, 32'h0);
    ws_cfg = 5;
    cyc(2);
    read_hi = 0; addr_unstable = 0; rprev = reads;
    tick_fetch("ws_w0", 23'h0, 16'hAAAA);
    chk("ws_read_cycles", read_hi, 32'd6);
    chk("ws_addr_stable", addr_unstable, 32'd0);
    chk("ws_one_read", reads - rprev, 32'd1);
    ws_cfg = 0;
    cyc(2);
    tick_held("ws_h", 16'hBBBB);

    // Tick during WAIT sets sticky overrun; restart in IDLE clears it.
    lat_cfg = 4;
    prev = sv_count;
    pulse_tick();
    chk("ov_addr", {9'd0, flash_address}, 32'h1);
    cyc(1);
    pulse_tick();
    wait_sample("ov_s", prev);
    chk("ov_sample", {16'd0, last_sample}, 32'h0001);
    chk("ov_set", {31'd0, overrun}, 32'd1);
    cyc(15);
    chk("ov_dropped", sv_count, prev + 1);
    chk("ov_sticky", {31'd0, overrun}, 32'd1);
    pulse_restart();
    chk("ov_clear", {31'd0, overrun}, 32'd0);
    chk("ov_rst_addr", {9'd0, flash_address}, 32'h0);

    // Forward stream over words 0..11.
    for (int i = 0; i < 24; i++) begin
      w = word_at(23'(i / 2));
      if (i % 2 == 0) tick_fetch("stream", 23'(i / 2), w[15:0]);
      else tick_held("stream_h", w[31:16]);
    end

    // Restart during WAIT at addr 12: sample still emitted, then START_ADDR.
    prev = sv_count;
    pulse_tick();
    chk("rs_addr12", {9'd0, flash_address}, 32'd12);
    cyc(1);
    pulse_restart();
    wait_sample("rs_s", prev);
    chk("rs_sample", {16'd0, last_sample}, 32'h000C);
    cyc(3);
    chk("rs_addr0", {9'd0, flash_address}, 32'h0);
    tick_fetch("rs_after", 23'h0, 16'hAAAA);
    tick_held("rs_afterh", 16'hBBBB);

    // Reset while in REQ: flash_read drops immediately.
    ws_cfg = 3;
    cyc(2);
    pulse_tick();
    chk("rq_read", {31'd0, flash_read}, 32'd1);
    chk("rq_addr1", {9'd0, flash_address}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rq_rst_read", {31'd0, flash_read}, 32'd0);
    chk("rq_rst_addr", {9'd0, flash_address}, 32'h0);
    cyc(2);
    reset = 1'b0;
    ws_cfg = 0;
    cyc(3);

    // Reset while in WAIT, late readdatavalid ignored.
    lat_cfg = 3;
    tick_fetch("pre", 23'h0, 16'hAAAA);
    tick_held("preh", 16'hBBBB);
    prev = sv_count;
    pulse_tick();
    chk("rw_addr1", {9'd0, flash_address}, 32'h1);
    cyc(1);
    reset = 1'b1;
    #1;
    chk("rw_read", {31'd0, flash_read}, 32'd0);
    chk("rw_sample", {16'd0, sample}, 32'h0);
    chk("rw_sv", {31'd0, sample_valid}, 32'd0);
    chk("rw_ovr", {31'd0, overrun}, 32'd0);
    chk("rw_addr", {9'd0, flash_address}, 32'h0);
    @(negedge clk_50);
    reset = 1'b0;
    cyc(6);
    chk("rw_no_sv", sv_count, prev);
    chk("rw_addr_after", {9'd0, flash_address}, 32'h0);
    chk("rw_sample_after", {16'd0, sample}, 32'h0);
    chk("rw_read_after", {31'd0, flash_read}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
